division_entera: RTL and testbench
==================================

DIVISION_ENTERA -- requirements
Module: division_entera

Interface
REQ-001 The module SHALL have parameter N, default 8, giving the operand and result width in bits.
REQ-002 Port clk SHALL be an input of width 1 and be the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input of width 1 and be an asynchronous, active-low reset.
REQ-004 Port start SHALL be an input of width 1 that requests a division; it is sampled only in IDLE.
REQ-005 Port A SHALL be an input of width N carrying the unsigned dividend.
REQ-006 Port B SHALL be an input of width N carrying the unsigned divisor.
REQ-007 Port Q SHALL be an output of width N carrying the registered unsigned quotient.
REQ-008 Port R SHALL be an output of width N carrying the registered unsigned remainder.
REQ-009 Port done SHALL be an output of width 1 pulsing high for one cycle when Q/R are valid.

Function
REQ-010 The design SHALL implement a three-state FSM with internal register state: IDLE, CALC and DONE.
REQ-011 In IDLE with start=1 at a rising edge, the design SHALL capture A into a 2N-bit register A_ext as {N zeros, A}, capture B, load down-counter count with N, and go to CALC.
REQ-012 In IDLE with start=0, the design SHALL remain in IDLE and hold Q, R unchanged.
REQ-013 Each CALC cycle SHALL perform one restoring step:
- shift A_ext left by 1;
- if the upper N bits are >= the latched B, subtract B from the upper half and set bit 0 to 1, else set bit 0 to 0;
- decrement count.
REQ-014 CALC SHALL last exactly N cycles; the transition to DONE SHALL occur on the edge where count goes from 1 to 0.
REQ-015 In DONE, Q SHALL equal the lower N bits of A_ext, R SHALL equal the upper N bits, done SHALL be 1 for that single cycle, and the next state SHALL be IDLE.
REQ-016 done SHALL rise exactly N+1 rising edges after the edge that sampled start (9 for N=8) and SHALL be 0 in all other cycles.
REQ-017 Q and R SHALL hold their last results until the next DONE.
REQ-018 start asserted while in CALC or DONE SHALL be ignored, and changes to A/B after capture SHALL not affect the result.
REQ-019 Divide by zero (latched B=0) SHALL use the same latency and SHALL produce Q = all ones and R = A.
REQ-020 All arithmetic SHALL be unsigned and N+1 bits wide for the trial subtraction, so there is no overflow for any A, B including 2^N-1.
REQ-021 start held high continuously SHALL launch a new division from IDLE on the cycle after DONE.

Reset
REQ-022 rst=0 SHALL immediately, asynchronously force state=IDLE, count=0, A_ext=0, Q=0, R=0 and done=0, regardless of clock.
REQ-023 Reset asserted mid-CALC SHALL abort the operation with no done pulse, and after release the module SHALL accept a new start normally.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Release reset, A=15, B=4, one-cycle start pulse -> done pulses once, 9 edges later, with Q=3, R=3.
- A=255, B=1 -> Q=255, R=0; then A=7, B=9 -> Q=0, R=7.
- A=100, B=0 -> Q=255, R=100, done latency 9 cycles.
- Start A=200, B=10; change A/B and pulse start during CALC -> Q=20, R=0, only one done pulse.
- Assert rst mid-CALC -> Q=R=0, done=0, state IDLE; then a new start with A=9, B=2 -> Q=4, R=1.
- A 2000 ns timeout SHALL flag a hang as failure.

Source files
------------

// File: rtl/division_entera.sv
// ============================================================================
// Module      : division_entera
// Description : Sequential unsigned restoring divider, one quotient bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module division_entera #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] a_ext_q, a_ext_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic           done_q, done_d;

  // Partial remainder after the shift; one extra bit so the compare never overflows.
  logic [N:0]     w_upper;
  logic           w_ge;
  logic [N-1:0]   w_rem;

  always_comb begin
    w_upper = a_ext_q[2*N-1:N-1];
    w_ge    = (w_upper >= {1'b0, b_q});
    w_rem   = w_ge ? N'(w_upper - {1'b0, b_q}) : w_upper[N-1:0];
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_ext_d = a_ext_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_ext_d = {{N{1'b0}}, A};
          b_d     = B;
          count_d = CW'(N);
          state_d = CALC;
        end
      end
      CALC: begin
        a_ext_d = {w_rem, a_ext_q[N-2:0], w_ge};
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        q_d     = a_ext_q[N-1:0];
        r_d     = a_ext_q[2*N-1:N];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      a_ext_q <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_ext_q <= a_ext_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_division_entera.sv
// ============================================================================
// Module      : tb_division_entera
// Description : Self-checking bench for division_entera against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_division_entera;

  localparam int N      = 8;
  localparam int BUDGET = 200;  // 200 cycles of 10 ns = 2000 ns hang limit

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         done;

  int compared;
  int mismatched;

  division_entera #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (a),
    .B    (b),
    .Q    (q),
    .R    (r),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Unsigned division; a zero divisor yields an all-ones quotient and the dividend as remainder.
  task automatic ref_div(input logic [N-1:0] ai, input logic [N-1:0] bi,
                         output logic [N-1:0] qe, output logic [N-1:0] re);
    if (bi == 0) begin
      qe = {N{1'b1}};
      re = ai;
    end else begin
      qe = N'(int'(ai) / int'(bi));
      re = N'(int'(ai) % int'(bi));
    end
  endtask

  task automatic run_div(input string tag, input logic [N-1:0] ai, input logic [N-1:0] bi,
                         input bit disturb);
    int lat;
    int extra;
    bit got;
    logic [N-1:0] qe, re, qs, rs;
    ref_div(ai, bi, qe, re);
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
      if (disturb && lat == 3) begin
        a = N'($urandom); b = N'($urandom); start = 1'b1;
      end
      if (disturb && lat == 4) start = 1'b0;
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(N + 1));
    chk({tag, "_Q"}, 32'(q), 32'(qe));
    chk({tag, "_R"}, 32'(r), 32'(re));
    qs = q; rs = r;
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk({tag, "_single_pulse"}, 32'(extra), 32'd0);
    chk({tag, "_hold_QR"}, 32'({q, r}), 32'({qs, rs}));
  endtask

  initial begin
    int cyc;
    int n;
    int first;
    int second;
    int extra;
    logic [N-1:0] qe, re, ra, rb;

    compared = 0; mismatched = 0;
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    #23;
    chk("reset_Q", 32'(q), 32'd0);
    chk("reset_R", 32'(r), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    run_div("d15_4",   8'd15,  8'd4,  1'b0);
    run_div("d255_1",  8'd255, 8'd1,  1'b0);
    run_div("d7_9",    8'd7,   8'd9,  1'b0);
    run_div("d100_0",  8'd100, 8'd0,  1'b0);
    run_div("d255_255",8'd255, 8'd255,1'b0);
    run_div("d200_10", 8'd200, 8'd10, 1'b1);

    // start held high: back-to-back divisions, second launched right after the first DONE
    ref_div(8'd50, 8'd7, qe, re);
    @(negedge clk);
    a = 8'd50; b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0; n = 0; first = 0; second = 0;
    while (n < 2 && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        n++;
        if (n == 1) first = cyc;
        else begin
          second = cyc;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("held_first_lat", 32'(first), 32'(N + 1));
    chk("held_second_lat", 32'(second), 32'(2 * N + 3));
    chk("held_Q", 32'(q), 32'(qe));
    chk("held_R", 32'(r), 32'(re));
    repeat (3) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      ra = N'($urandom);
      rb = (i % 5 == 0) ? '0 : N'($urandom_range(1, 255));
      run_div($sformatf("rnd%0d", i), ra, rb, (i % 4) == 1);
    end

    // reset in the middle of a calculation
    @(negedge clk);
    a = 8'd123; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_Q", 32'(q), 32'd0);
    chk("midrst_R", 32'(r), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("midrst_no_done", 32'(extra), 32'd0);
    run_div("after_rst_9_2", 8'd9, 8'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
